// File: rtl/read_fwft_if.sv
// Read-side FIFO bus: everything read_fwft exchanges with the rest of the
// FIFO except clock and reset.
//   w_ptr_sync     gray write pointer, already synchronised into r_clk
//   r_ptr_gray     registered gray read pointer, sent to the write side
//   r_en / r_addr  synchronous-read RAM port request
//   r_data_ram     RAM read data, valid one clock after r_en
//   r_data/r_valid/r_ready  first-word-fall-through consumer handshake
//   r_empty, r_almost_empty, r_level  occupancy status
// master = the read controller, slave = RAM / pointer sync / consumer side.
interface read_fwft_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH:0]   w_ptr_sync;
    logic [ADDR_WIDTH:0]   r_ptr_gray;
    logic                  r_en;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data_ram;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_ready;
    logic                  r_empty;
    logic                  r_almost_empty;
    logic [ADDR_WIDTH+1:0] r_level;

    modport master (
        input  w_ptr_sync, r_data_ram, r_ready,
        output r_ptr_gray, r_en, r_addr, r_data, r_valid, r_empty,
               r_almost_empty, r_level
    );

    modport slave (
        output w_ptr_sync, r_data_ram, r_ready,
        input  r_ptr_gray, r_en, r_addr, r_data, r_valid, r_empty,
               r_almost_empty, r_level
    );
endinterface

// File: rtl/read_fwft.sv
// Read-side controller of a dual-clock FIFO (r_clk domain).
// Owns the binary/gray read pointer, issues synchronous RAM reads and keeps a
// 2-entry output buffer so data falls through to r_data with a valid/ready
// handshake at one word per clock.
// Ports:
//   r_clk    read clock
//   r_rst_n  asynchronous active-low reset
//   bus      read_fwft_if.master (pointer exchange, RAM port, consumer, status)
module read_fwft #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8,
    parameter int AE_THRESH  = 4
) (
    input  logic         r_clk,
    input  logic         r_rst_n,
    read_fwft_if.master  bus
);
    localparam int PW = ADDR_WIDTH + 1;   // pointer width (extra wrap bit)
    localparam int LW = ADDR_WIDTH + 2;   // level width, holds depth+2

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [PW-1:0]         r_ptr_bin_reg, r_ptr_bin_next;
    logic [PW-1:0]         r_ptr_gray_reg;
    logic                  pend_reg, pend_next;
    logic [1:0]            buf_cnt_reg, buf_cnt_next;
    logic [DATA_WIDTH-1:0] head_reg, head_next;
    logic [DATA_WIDTH-1:0] second_reg, second_next;
    logic                  valid_reg, empty_reg, ae_reg, ae_next;
    logic [LW-1:0]         level_reg, level_next;

    logic [PW-1:0] w_bin;
    logic          ptr_empty;
    logic          pop;
    logic [2:0]    occ;
    logic          rd_en;

    // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
    generate
        for (genvar gi = 0; gi < PW; gi++) begin : g_w_bin
            assign w_bin[gi] = ^bus.w_ptr_sync[PW-1:gi];
        end
    endgenerate

    assign ptr_empty = (bin2gray(r_ptr_bin_reg) == bus.w_ptr_sync);
    assign pop       = valid_reg & bus.r_ready;

    // Words that will sit in the buffer after this edge if nothing new is
    // fetched; a fetch is allowed only while that leaves room for its arrival.
    // pop implies buf_cnt >= 1, so this never underflows.
    assign occ   = {1'b0, buf_cnt_reg} + {2'b00, pend_reg} - {2'b00, pop};
    assign rd_en = ~ptr_empty & (occ < 3'd2);

    assign r_ptr_bin_next = r_ptr_bin_reg + PW'(rd_en);
    assign pend_next      = rd_en;

    always_comb begin
        head_next    = head_reg;
        second_next  = second_reg;
        buf_cnt_next = buf_cnt_reg;
        case ({pend_reg, pop})
            2'b10: begin
                // Arrival only: fill the first free slot.
                if (buf_cnt_reg == 2'd0) begin
                    head_next = bus.r_data_ram;
                end else begin
                    second_next = bus.r_data_ram;
                end
                buf_cnt_next = buf_cnt_reg + 2'd1;
            end
            2'b11: begin
                // Arrival and pop together: shift, count unchanged.
                if (buf_cnt_reg == 2'd1) begin
                    head_next = bus.r_data_ram;
                end else begin
                    head_next   = second_reg;
                    second_next = bus.r_data_ram;
                end
            end
            2'b01: begin
                if (buf_cnt_reg == 2'd2) begin
                    head_next = second_reg;
                end
                buf_cnt_next = buf_cnt_reg - 2'd1;
            end
            default: ;
        endcase
    end

    // Level counts RAM words not yet fetched, the in-flight read and the buffer.
    always_comb begin
        level_next = LW'(PW'(w_bin - r_ptr_bin_next)) + LW'(pend_next) + LW'(buf_cnt_next);
        ae_next    = (level_next <= LW'(AE_THRESH));
    end

    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            r_ptr_bin_reg  <= '0;
            r_ptr_gray_reg <= '0;
            pend_reg       <= 1'b0;
            buf_cnt_reg    <= 2'd0;
            head_reg       <= '0;
            second_reg     <= '0;
            valid_reg      <= 1'b0;
            empty_reg      <= 1'b1;
            level_reg      <= '0;
            ae_reg         <= 1'b1;
        end else begin
            r_ptr_bin_reg  <= r_ptr_bin_next;
            r_ptr_gray_reg <= bin2gray(r_ptr_bin_next);
            pend_reg       <= pend_next;
            buf_cnt_reg    <= buf_cnt_next;
            head_reg       <= head_next;
            second_reg     <= second_next;
            valid_reg      <= (buf_cnt_next != 2'd0);
            empty_reg      <= (buf_cnt_next == 2'd0);
            level_reg      <= level_next;
            ae_reg         <= ae_next;
        end
    end

    assign bus.r_ptr_gray     = r_ptr_gray_reg;
    assign bus.r_en           = rd_en;
    assign bus.r_addr         = r_ptr_bin_reg[ADDR_WIDTH-1:0];
    assign bus.r_data         = head_reg;
    assign bus.r_valid        = valid_reg;
    assign bus.r_empty        = empty_reg;
    assign bus.r_almost_empty = ae_reg;
    assign bus.r_level        = level_reg;
endmodule

// File: tb/tb_read_fwft.sv
// Bench for read_fwft with a small RAM (ADDR_WIDTH=3) so pointer wrap happens
// often. The reference model is a word queue plus written/popped counters:
// level = written - popped, data must leave in write order.
module tb_read_fwft;
    localparam int AW    = 3;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;
    localparam int PMASK = (1 << (AW + 1)) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    read_fwft_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    read_fwft #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AE_THRESH(4)) dut (
        .r_clk   (clk),
        .r_rst_n (rst_n),
        .bus     (bus)
    );

    // Synchronous-read RAM model.
    logic [DW-1:0] ram [DEPTH];
    int fetches = 0;
    always @(posedge clk) begin
        if (bus.r_en) begin
            bus.r_data_ram <= ram[bus.r_addr];
            fetches        <= fetches + 1;
        end
    end

    // Reference model state.
    logic [DW-1:0] q[$];
    int wr = 0;
    int pops = 0;
    int exp_level = 0;
    int seq = 1;
    logic [AW:0] prev_g = '0;
    logic last_pop = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [AW:0] to_gray(input int v);
        logic [AW:0] b;
        b = v[AW:0];
        return b ^ (b >> 1);
    endfunction

    function automatic int from_gray(input logic [AW:0] g);
        logic [AW+1:0] b;
        b = '0;
        for (int i = AW; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return int'(b);
    endfunction

    task automatic push_word(input logic [DW-1:0] d);
        ram[wr % DEPTH] = d;
        q.push_back(d);
        wr++;
        bus.w_ptr_sync = to_gray(wr);
    endtask

    // Status checks on the registered outputs, done at the falling edge.
    task automatic do_checks();
        int ahead, limit;
        check_eq("level", bus.r_level, exp_level);
        check_eq("almost_empty", bus.r_almost_empty, exp_level <= 4);
        check_eq("empty_is_not_valid", bus.r_empty, !bus.r_valid);
        if (bus.r_valid) check_eq("valid_has_word", q.size() != 0, 1);
        check_eq("gray_one_bit_step", $countones(bus.r_ptr_gray ^ prev_g) <= 1, 1);
        prev_g = bus.r_ptr_gray;
        ahead = (from_gray(bus.r_ptr_gray) - pops) & PMASK;
        limit = (wr - pops < 3) ? wr - pops : 3;
        check_eq("ptr_not_past_write", ahead <= limit, 1);
    endtask

    // One clock: drive at the falling edge, pop-check, then check after the edge.
    task automatic cyc(input logic rdy, input int nwr);
        logic [DW-1:0] e;
        bus.r_ready = rdy;
        for (int n = 0; n < nwr; n++) begin
            if (wr - pops < DEPTH) begin
                push_word(DW'(seq));
                seq++;
            end
        end
        last_pop = bus.r_valid & rdy;
        if (last_pop) begin
            if (q.size() == 0) begin
                check_eq("pop_with_model_empty", 1, 0);
            end else begin
                e = q.pop_front();
                check_eq("data_order", bus.r_data, e);
                $display("pop data=%02h level_before=%0d", bus.r_data, exp_level);
            end
            pops++;
        end
        @(posedge clk);
        exp_level = wr - pops;
        @(negedge clk);
        do_checks();
    endtask

    int first_pop, last_pop_idx, pop_cnt, f0;
    logic [DW-1:0] held;

    initial begin
        bus.w_ptr_sync = '0;
        bus.r_ready    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_valid", bus.r_valid, 0);
        check_eq("rst_empty", bus.r_empty, 1);
        rst_n = 1'b1;

        // Idle after reset.
        @(negedge clk);
        check_eq("idle_valid", bus.r_valid, 0);
        check_eq("idle_empty", bus.r_empty, 1);
        check_eq("idle_level", bus.r_level, 0);
        check_eq("idle_ae", bus.r_almost_empty, 1);
        check_eq("idle_ren", bus.r_en, 0);
        check_eq("idle_data", bus.r_data, 0);

        // Single word, latency 2.
        push_word(8'hA5);
        #1;
        check_eq("first_ren", bus.r_en, 1);
        check_eq("first_addr", bus.r_addr, 0);
        @(posedge clk);
        @(negedge clk);
        check_eq("lat1_valid", bus.r_valid, 0);
        check_eq("lat1_gray", bus.r_ptr_gray, 1);
        check_eq("lat1_level", bus.r_level, 1);
        prev_g = bus.r_ptr_gray;
        @(posedge clk);
        @(negedge clk);
        check_eq("lat2_valid", bus.r_valid, 1);
        check_eq("lat2_data", bus.r_data, 8'hA5);
        check_eq("lat2_level", bus.r_level, 1);
        exp_level = 1;
        cyc(1'b1, 0);
        check_eq("after_pop_empty", bus.r_empty, 1);
        cyc(1'b0, 0);

        // Burst of 8 with r_ready held: 8 back-to-back pops.
        cyc(1'b1, 8);
        first_pop = -1;
        last_pop_idx = -1;
        pop_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            cyc(1'b1, 0);
            if (last_pop) begin
                if (first_pop < 0) first_pop = i;
                last_pop_idx = i;
                pop_cnt++;
            end
        end
        check_eq("burst_latency", first_pop, 1);
        check_eq("burst_count", pop_cnt, 8);
        check_eq("burst_no_bubble", last_pop_idx - first_pop + 1, 8);

        // Back-pressure: 5 words, consumer stalled.
        f0 = fetches;
        cyc(1'b0, 5);
        repeat (2) cyc(1'b0, 0);
        held = bus.r_data;
        repeat (4) cyc(1'b0, 0);
        check_eq("stall_fetches", fetches - f0, 2);
        check_eq("stall_level", bus.r_level, 5);
        check_eq("stall_data_stable", bus.r_data, held);
        check_eq("stall_head", bus.r_data, q[0]);
        check_eq("stall_ren_off", bus.r_en, 0);
        repeat (12) cyc(1'b1, 0);

        // Random stream through many pointer wraps.
        f0 = pops;
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2));
        end
        check_eq("stream_progress", (pops - f0) >= 20, 1);

        // Reset with a read in flight and a word buffered.
        for (int i = 0; i < 20 && q.size() != 0; i++) cyc(1'b1, 0);
        cyc(1'b0, 5);
        cyc(1'b0, 0);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", bus.r_valid, 0);
        check_eq("mid_rst_empty", bus.r_empty, 1);
        check_eq("mid_rst_level", bus.r_level, 0);
        check_eq("mid_rst_ae", bus.r_almost_empty, 1);
        check_eq("mid_rst_data", bus.r_data, 0);
        check_eq("mid_rst_gray", bus.r_ptr_gray, 0);
        q.delete();
        wr = 0;
        pops = 0;
        exp_level = 0;
        prev_g = '0;
        bus.w_ptr_sync = '0;
        bus.r_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 80; i++) begin
            cyc($urandom_range(0, 2) != 0, $urandom_range(0, 2));
        end

        // Drain, bounded.
        for (int i = 0; i < 40 && q.size() != 0; i++) cyc(1'b1, 0);
        check_eq("drain_empty", q.size(), 0);
        cyc(1'b1, 0);
        check_eq("final_empty", bus.r_empty, 1);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule
